// File: rtl/led_sequencer.sv
// led_sequencer: steps a colour code through [MIN_CODE..MAX_CODE] under button control with level/edge/prescaled triggers, direction and ping-pong
module led_sequencer #(
   parameter int WIDTH    = 3,
   parameter int MIN_CODE = 1,
   parameter int MAX_CODE = 6,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             button,
   input  logic [1:0]       trig_mode,
   input  logic             dir,
   input  logic             pingpong,
   output logic [WIDTH-1:0] colour,
   output logic             step,
   output logic             wrap
);
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] TOP = CW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] LO = WIDTH'(MIN_CODE);
   localparam logic [WIDTH-1:0] HI = WIDTH'(MAX_CODE);
   localparam logic [WIDTH-1:0] LO_UP = WIDTH'(MIN_CODE + 1);
   localparam logic [WIDTH-1:0] HI_DN = WIDTH'(MAX_CODE - 1);
   typedef enum logic {UP, DN} pd_t;
   pd_t pd, pd_n;
   logic [CW-1:0] cnt, cnt_n;
   logic btn_q, req, wr, in_rng, eff_dn, pre_on;
   logic [WIDTH-1:0] nxt;
   // trigger decode, prescale counter and next colour / ping-pong direction
   always_comb begin
      pre_on = (trig_mode == 2'b10) && button;
      cnt_n  = (pre_on && cnt != TOP) ? cnt + CW'(1) : '0;
      req    = (trig_mode == 2'b00) ? button :
               (trig_mode == 2'b01) ? button & ~btn_q :
               (trig_mode == 2'b10) ? pre_on && cnt == TOP : 1'b0;
      in_rng = colour >= LO && colour <= HI;
      eff_dn = pingpong ? (pd == DN) : dir;
      nxt    = colour;
      pd_n   = pd;
      wr     = 1'b0;
      if (!in_rng) begin
         nxt = eff_dn ? HI : LO;
      end else if (MIN_CODE == MAX_CODE) begin
         wr = 1'b1;
      end else if (!pingpong) begin
         wr  = eff_dn ? colour == LO : colour == HI;
         nxt = eff_dn ? (wr ? HI : colour - 1'b1) : (wr ? LO : colour + 1'b1);
      end else if (pd == UP && colour == HI) begin
         nxt  = HI_DN;
         pd_n = DN;
         wr   = 1'b1;
      end else if (pd == DN && colour == LO) begin
         nxt  = LO_UP;
         pd_n = UP;
         wr   = 1'b1;
      end else begin
         nxt = (pd == DN) ? colour - 1'b1 : colour + 1'b1;
      end
   end
   // state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         colour <= '0;
         step   <= 1'b0;
         wrap   <= 1'b0;
         cnt    <= '0;
         btn_q  <= 1'b0;
         pd     <= UP;
      end else begin
         btn_q <= button;
         cnt   <= cnt_n;
         step  <= req;
         wrap  <= req & wr;
         if (req) begin
            colour <= nxt;
            pd     <= pd_n;
         end
      end
   end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised successor to the 3-bit dynamic LED colour cycler.
- Steps a colour code through a configurable range [MIN_CODE..MAX_CODE] under button control.
- Adds selectable trigger modes (level, edge, prescaled auto-run), up/down direction, ping-pong sweep, and step/wrap status pulses.
- Sits between the debounced board button and the RGB LED driver.

Parameters:
- WIDTH, 3, colour code width in bits.
- MIN_CODE, 1, lowest code in the cycle. Legal range: 0 < MIN_CODE <= MAX_CODE.
- MAX_CODE, 6, highest code in the cycle. Legal range: MAX_CODE <= 2^WIDTH-1.
- PRESCALE, 4, clock cycles per step in prescaled mode. Must be >= 1. Counter width is clog2(PRESCALE), minimum 1 bit.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- button  in  1  step request/enable, already synchronised to clk.
- trig_mode  in  2  00 level, 01 rising edge, 10 prescaled level, 11 reserved (never steps).
- dir  in  1  0 = up, 1 = down. Ignored when pingpong=1.
- pingpong  in  1  1 = bounce between endpoints instead of wrapping.
- colour  out  WIDTH  current colour code, registered.
- step  out  1  one-cycle pulse, high in the cycle after a step was taken.
- wrap  out  1  one-cycle pulse, high in the cycle after a wrap or ping-pong turnaround.

Behaviour:
- All state updates happen on posedge clk. rst is sampled on the edge only and is active-low.
- rst=0 at an edge forces:
  - colour=0, step=0, wrap=0
  - prescale count=0
  - edge register btn_q=0
  - internal ping-pong direction pd=up
- rst has priority over every other input.
- btn_q <= button every non-reset cycle.
- Step request (req) is evaluated from the inputs sampled at the edge:
  - trig_mode 00: req = button.
  - trig_mode 01: req = button & ~btn_q. Exactly one step per press, regardless of press length.
  - trig_mode 10: while button=1 the count increments. When count == PRESCALE-1, req=1 and count <= 0. While button=0 or trig_mode != 10, count <= 0 (holds at 0). PRESCALE=1 behaves as mode 00.
  - trig_mode 11: req=0.
- No req: colour, pd hold; step=0, wrap=0.
- req with colour outside [MIN_CODE..MAX_CODE] (including the post-reset 0):
  - Effective direction up: colour <= MIN_CODE.
  - Effective direction down: colour <= MAX_CODE.
  - step=1, wrap=0. In ping-pong, pd is left unchanged.
- Effective direction: dir when pingpong=0, pd when pingpong=1.
- req, in range, pingpong=0:
  - Up: colour==MAX_CODE -> MIN_CODE with wrap=1; else colour+1.
  - Down: colour==MIN_CODE -> MAX_CODE with wrap=1; else colour-1.
  - step=1.
- req, in range, pingpong=1:
  - pd=up and colour==MAX_CODE: colour <= MAX_CODE-1, pd <= down, wrap=1.
  - pd=down and colour==MIN_CODE: colour <= MIN_CODE+1, pd <= up, wrap=1.
  - Otherwise: step by pd, wrap=0.
  - step=1 in all cases.
- MIN_CODE==MAX_CODE: every in-range req leaves colour unchanged, step=1, wrap=1, pd unchanged.
- Arithmetic is WIDTH bits. No over/underflow can occur because range checks precede increment/decrement.
- Latency: colour, step and wrap change at the same edge that samples req. They are visible one cycle after button/mode are presented.
- Mid-operation changes:
  - Toggling pingpong or dir takes effect on the next req; pd is not reset.
  - Changing trig_mode clears count on the same edge.
  - Reset asserted mid-sequence returns to colour=0; the first req afterwards goes to MIN_CODE (up) or MAX_CODE (down).

Test Plan:
- Reset and level mode (defaults, trig_mode=00, dir=0, pingpong=0):
  - rst=0 for 2 cycles -> colour=0, step=0, wrap=0.
  - Release rst, button=1 for 8 cycles -> colour 1,2,3,4,5,6,1,2. wrap high only in the cycle after 6->1.
  - button=0 -> colour holds at 2, step=0.
- Edge mode (trig_mode=01, starting at colour=2):
  - Hold button for 10 cycles -> exactly one step, colour=3.
  - Release 1 cycle, press again -> colour=4.
- Prescaled mode (trig_mode=10, PRESCALE=4, starting at 4):
  - button=1 for 12 cycles -> colour 5 after cycle 4, 6 after cycle 8, 1 after cycle 12 with wrap=1.
  - Drop button at count 2, re-assert -> next step 4 cycles after re-assert.
- Down and out-of-range (dir=1, level mode):
  - From reset, button=1 for 3 cycles -> colour 6,5,4.
  - From colour=1, one req -> colour 6, wrap=1.
- Ping-pong (pingpong=1, level mode, from reset):
  - button=1 for 12 cycles -> 1,2,3,4,5,6,5,4,3,2,1,2. wrap pulses after 6->5 and after 1->2.
- Reset mid-operation:
  - At colour=5 in ping-pong down, assert rst=0 for 1 cycle -> colour=0, pd=up.
  - Next req -> colour=1.
